keycode_decoder: RTL and testbench
==================================

# keycode_decoder

Turns the 24-bit keycode word written by the NIOS into the keycode PIO (three USB HID usage codes) into frame-synchronous game commands: held directions, a fire pulse with auto-repeat, and a pause toggle. It samples the PIO output once per video frame, so the player and projectile logic downstream sees a coherent snapshot. Sits between the keycode PIO `out_port` and the game-logic/sprite-position blocks.

## Interface
- `REPEAT_DELAY`, 20: frames from the first fire pulse to the first auto-repeat pulse (1..255).
- `REPEAT_PERIOD`, 6: frames between subsequent auto-repeat pulses (1..255).
- `clk`  in  1  system clock (50 MHz).
- `reset`  in  1  asynchronous, active-high reset.
- `keycode`  in  24  three HID codes: slot0 = [7:0], slot1 = [15:8], slot2 = [23:16]; 0x00 = empty slot.
- `frame_tick`  in  1  one-`clk` pulse per frame (from the VGA controller at vsync start).
- `up`, `down`, `left`, `right`  out  1 each  held direction levels, after cancellation.
- `fire_pulse`  out  1  one-`clk` pulse per fire event.
- `paused`  out  1  pause state level.
- `any_key`  out  1  at least one valid non-zero code in the current snapshot.

## Operation
- Key map (HID): W 0x1A = up, S 0x16 = down, A 0x04 = left, D 0x07 = right, Space 0x2C = fire, Esc 0x29 = pause.
- Hit vector: a key is "now pressed" if its code appears in any slot. Duplicate codes are ORed. Unmapped codes contribute only to `any_key`.
- Rollover: if any slot is 0x01 (HID ErrorRollOver), the snapshot is discarded. `key_now` keeps its previous value and `key_prev` is not updated.
- On each `frame_tick`: `key_prev <= key_now`, `key_now <= hit vector` (subject to the rollover rule).
- Direction cancellation: if up and down are both pressed, both outputs are 0. Left/right behave the same way.
- Pause: `paused` toggles on each Esc press edge (Esc in `key_now` and not in `key_prev`). Holding Esc does not toggle again.
- While `paused`=1, all direction outputs are forced to 0, `fire_pulse` is suppressed, and the fire FSM is held in IDLE.
- Fire FSM (8-bit counter `cnt`), evaluated on the cycle after a tick (`tick_d`):
  - IDLE: on a fire press edge, pulse, set cnt = 1, go to DELAY.
  - DELAY: if fire is released, go to IDLE. Else if cnt == REPEAT_DELAY, pulse, set cnt = 1, go to REPEAT. Else cnt++.
  - REPEAT: if fire is released, go to IDLE. Else if cnt == REPEAT_PERIOD, pulse, set cnt = 1. Else cnt++.
  - Result for a press first seen at tick N: pulses at ticks N, N+REPEAT_DELAY, N+REPEAT_DELAY+k·REPEAT_PERIOD.
- Pause press and fire press in the same snapshot: the pause toggle wins, so no pulse is produced when entering pause. On unpause, a fire key still held does not pulse; a fresh press edge is required.

## Timing
- Reset (async): `key_now`, `key_prev`, `paused`, all outputs, `cnt` and `tick_d` go to 0; FSM goes to IDLE. This applies mid-frame or mid-repeat; after release, the next tick is treated as the first snapshot.
- Latency: `keycode` is sampled at the `clk` edge where `frame_tick`=1. Outputs update exactly one `clk` later, at the `tick_d` edge.
- `fire_pulse` is high for exactly one `clk`, on the `tick_d` cycle.
- Level outputs (`up`, `down`, `left`, `right`, `paused`, `any_key`) change only at `tick_d` edges and are stable for a whole frame.
- `keycode` changes between ticks are ignored. Back-to-back ticks (on consecutive cycles) must be handled correctly.

## Structure
- Package `keycode_pkg`: HID constants (KEY_W, KEY_A, KEY_S, KEY_D, KEY_SPACE, KEY_ESC, KEY_ROLLOVER, KEY_NONE), the hit-vector bit indices, and the fire FSM state enum.
- Sub-module `key_repeat`: fire FSM plus counter, parameterised by REPEAT_DELAY and REPEAT_PERIOD. Inputs: `clk`, `reset`, `step` (tick_d), `held`, `enable`. Output: `pulse`.

## Test plan
- Reset, then keycode=0x00001A with one tick → `up`=1 one `clk` after the tick; all other outputs 0.
- keycode=0x1A1607 → up=0, down=0, right=1 (up/down cancel).
- Space held for 40 ticks with REPEAT_DELAY=20, REPEAT_PERIOD=6 → `fire_pulse` at ticks 0, 20, 26, 32, 38, each one `clk` wide; releasing it stops the pulses.
- Esc pressed for 3 ticks, released, pressed again → `paused` 0→1 on the first tick, stays 1, returns to 0 on the second press; directions forced 0 while paused.
- Snapshot 0x00001A, then 0x01012C → outputs hold `up`=1 with no fire pulse (rollover discarded); next snapshot 0x00002C → fire pulse, `up`=0.
- Assert `reset` mid-REPEAT with Space held → outputs 0 immediately; after release, the first tick with Space held gives a pulse (treated as a new press edge).

Source files
------------

// File: rtl/keycode_pkg.sv
// Purpose: shared HID usage codes, hit-vector bit positions and fire FSM
//          encoding for the keycode decoder, plus helpers that decode a
//          24-bit keycode PIO word (three 8-bit HID slots) into a hit vector.
// Latency: combinational helpers only.
// Backpressure: none.
package keycode_pkg;

  // HID keyboard usage codes
  localparam logic [7:0] KEY_NONE     = 8'h00;
  localparam logic [7:0] KEY_ROLLOVER = 8'h01;
  localparam logic [7:0] KEY_A        = 8'h04;
  localparam logic [7:0] KEY_D        = 8'h07;
  localparam logic [7:0] KEY_S        = 8'h16;
  localparam logic [7:0] KEY_W        = 8'h1A;
  localparam logic [7:0] KEY_ESC      = 8'h29;
  localparam logic [7:0] KEY_SPACE    = 8'h2C;

  // Hit-vector bit indices
  localparam int HIT_UP    = 0;
  localparam int HIT_DOWN  = 1;
  localparam int HIT_LEFT  = 2;
  localparam int HIT_RIGHT = 3;
  localparam int HIT_FIRE  = 4;
  localparam int HIT_PAUSE = 5;
  localparam int HIT_W     = 6;

  typedef logic [HIT_W-1:0] hit_t;

  typedef enum logic [1:0] {
    FIRE_IDLE   = 2'd0,
    FIRE_DELAY  = 2'd1,
    FIRE_REPEAT = 2'd2
  } fire_state_e;

  // One-hot hit for a single slot; unmapped codes give no hit.
  function automatic hit_t code_hit(input logic [7:0] code);
    hit_t h;
    h = '0;
    case (code)
      KEY_W:     h[HIT_UP]    = 1'b1;
      KEY_S:     h[HIT_DOWN]  = 1'b1;
      KEY_A:     h[HIT_LEFT]  = 1'b1;
      KEY_D:     h[HIT_RIGHT] = 1'b1;
      KEY_SPACE: h[HIT_FIRE]  = 1'b1;
      KEY_ESC:   h[HIT_PAUSE] = 1'b1;
      default:   h = '0;
    endcase
    return h;
  endfunction

  // Duplicate codes across slots simply OR together.
  function automatic hit_t snapshot_hits(input logic [23:0] kc);
    return code_hit(kc[7:0]) | code_hit(kc[15:8]) | code_hit(kc[23:16]);
  endfunction

  function automatic logic snapshot_rollover(input logic [23:0] kc);
    return (kc[7:0] == KEY_ROLLOVER) || (kc[15:8] == KEY_ROLLOVER) ||
           (kc[23:16] == KEY_ROLLOVER);
  endfunction

  function automatic logic snapshot_any(input logic [23:0] kc);
    return (kc[7:0] != KEY_NONE) || (kc[15:8] != KEY_NONE) ||
           (kc[23:16] != KEY_NONE);
  endfunction

endpackage

// File: rtl/key_repeat.sv
// Purpose: fire auto-repeat FSM. A press edge pulses immediately, then again
//          after REPEAT_DELAY steps, then every REPEAT_PERIOD steps while held.
// Latency: pulse is registered, high for the one clk following a step edge.
// Backpressure: none; enable=0 forces IDLE and suppresses pulses.
// Ports:
//   clk, reset  - clock, async active-high reset
//   step        - one-clk strobe per frame (evaluation point)
//   held        - fire key held in the current snapshot
//   enable      - low while the game is paused
//   pulse       - one-clk fire event
module key_repeat
  import keycode_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY  = 20,
  parameter int unsigned REPEAT_PERIOD = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic step,
  input  logic held,
  input  logic enable,
  output logic pulse
);

  localparam logic [7:0] DELAY_CNT  = 8'(REPEAT_DELAY);
  localparam logic [7:0] PERIOD_CNT = 8'(REPEAT_PERIOD);

  fire_state_e state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        held_prev_q, held_prev_d;
  logic        pulse_q, pulse_d;

  // held_prev tracks the key on every step, even while disabled, so a key
  // held through a pause (or through a discarded snapshot, where held does
  // not change) never looks like a fresh press.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    held_prev_d = held_prev_q;
    pulse_d     = 1'b0;
    if (step) begin
      held_prev_d = held;
      if (!enable) begin
        state_d = FIRE_IDLE;
        cnt_d   = 8'd0;
      end else begin
        case (state_q)
          FIRE_IDLE: begin
            if (held && !held_prev_q) begin
              pulse_d = 1'b1;
              cnt_d   = 8'd1;
              state_d = FIRE_DELAY;
            end
          end
          FIRE_DELAY: begin
            if (!held) begin
              state_d = FIRE_IDLE;
              cnt_d   = 8'd0;
            end else if (cnt_q == DELAY_CNT) begin
              pulse_d = 1'b1;
              cnt_d   = 8'd1;
              state_d = FIRE_REPEAT;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
          FIRE_REPEAT: begin
            if (!held) begin
              state_d = FIRE_IDLE;
              cnt_d   = 8'd0;
            end else if (cnt_q == PERIOD_CNT) begin
              pulse_d = 1'b1;
              cnt_d   = 8'd1;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
          default: begin
            state_d = FIRE_IDLE;
            cnt_d   = 8'd0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= FIRE_IDLE;
      cnt_q       <= 8'd0;
      held_prev_q <= 1'b0;
      pulse_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      held_prev_q <= held_prev_d;
      pulse_q     <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/keycode_decoder.sv
// Purpose: samples the keycode PIO word once per frame and produces held
//          directions (with opposite-direction cancellation), an auto-repeat
//          fire pulse and an Esc-toggled pause level.
// Latency: keycode sampled at the frame_tick edge; outputs update one clk
//          later (tick_d edge) and levels then hold for the whole frame.
// Backpressure: none; keycode changes between ticks are ignored.
// Ports:
//   clk, reset               - 50 MHz clock, async active-high reset
//   keycode[23:0]            - three HID slots, 0x00 = empty
//   frame_tick               - one-clk strobe per frame
//   up/down/left/right       - direction levels
//   fire_pulse               - one-clk fire event
//   paused, any_key          - pause state, any non-empty slot in snapshot
module keycode_decoder
  import keycode_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY  = 20,
  parameter int unsigned REPEAT_PERIOD = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] keycode,
  input  logic        frame_tick,
  output logic        up,
  output logic        down,
  output logic        left,
  output logic        right,
  output logic        fire_pulse,
  output logic        paused,
  output logic        any_key
);

  hit_t hits;
  logic rollover;
  logic any_now;

  logic tick_d_q, tick_d_d;
  hit_t key_now_q, key_now_d;
  // Only Esc needs its previous value here; fire history lives in key_repeat.
  logic esc_prev_q, esc_prev_d;
  logic any_now_q, any_now_d;
  // Cleared when the last snapshot was discarded, so an edge already acted
  // on is not seen a second time.
  logic snap_ok_q, snap_ok_d;
  logic paused_q, paused_d;
  logic up_q, up_d;
  logic down_q, down_d;
  logic left_q, left_d;
  logic right_q, right_d;
  logic any_key_q, any_key_d;
  logic esc_edge;

  assign hits     = snapshot_hits(keycode);
  assign rollover = snapshot_rollover(keycode);
  assign any_now  = snapshot_any(keycode);

  always_comb begin
    tick_d_d   = frame_tick;
    key_now_d  = key_now_q;
    esc_prev_d = esc_prev_q;
    any_now_d  = any_now_q;
    snap_ok_d  = snap_ok_q;
    paused_d   = paused_q;
    up_d       = up_q;
    down_d     = down_q;
    left_d     = left_q;
    right_d    = right_q;
    any_key_d  = any_key_q;
    esc_edge   = snap_ok_q & key_now_q[HIT_PAUSE] & ~esc_prev_q;

    // Snapshot stage
    if (frame_tick) begin
      snap_ok_d = ~rollover;
      if (!rollover) begin
        esc_prev_d = key_now_q[HIT_PAUSE];
        key_now_d  = hits;
        any_now_d  = any_now;
      end
    end

    // Output stage, one clk after the snapshot
    if (tick_d_q) begin
      paused_d  = paused_q ^ esc_edge;
      up_d      = key_now_q[HIT_UP] & ~key_now_q[HIT_DOWN] & ~paused_d;
      down_d    = key_now_q[HIT_DOWN] & ~key_now_q[HIT_UP] & ~paused_d;
      left_d    = key_now_q[HIT_LEFT] & ~key_now_q[HIT_RIGHT] & ~paused_d;
      right_d   = key_now_q[HIT_RIGHT] & ~key_now_q[HIT_LEFT] & ~paused_d;
      any_key_d = any_now_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_d_q   <= 1'b0;
      key_now_q  <= '0;
      esc_prev_q <= 1'b0;
      any_now_q  <= 1'b0;
      snap_ok_q  <= 1'b0;
      paused_q   <= 1'b0;
      up_q       <= 1'b0;
      down_q     <= 1'b0;
      left_q     <= 1'b0;
      right_q    <= 1'b0;
      any_key_q  <= 1'b0;
    end else begin
      tick_d_q   <= tick_d_d;
      key_now_q  <= key_now_d;
      esc_prev_q <= esc_prev_d;
      any_now_q  <= any_now_d;
      snap_ok_q  <= snap_ok_d;
      paused_q   <= paused_d;
      up_q       <= up_d;
      down_q     <= down_d;
      left_q     <= left_d;
      right_q    <= right_d;
      any_key_q  <= any_key_d;
    end
  end

  // enable uses the post-toggle pause state so a pause press in the same
  // snapshot as a fire press suppresses that pulse.
  key_repeat #(
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD)
  ) u_fire (
    .clk    (clk),
    .reset  (reset),
    .step   (tick_d_q),
    .held   (key_now_q[HIT_FIRE]),
    .enable (~paused_d),
    .pulse  (fire_pulse)
  );

  assign up      = up_q;
  assign down    = down_q;
  assign left    = left_q;
  assign right   = right_q;
  assign paused  = paused_q;
  assign any_key = any_key_q;

endmodule

// File: tb/tb_keycode_decoder.sv
// Directed bench for keycode_decoder with REPEAT_DELAY=20, REPEAT_PERIOD=6.
// Output vector order: {up, down, left, right, paused, any_key, fire_pulse}.
module tb_keycode_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] keycode;
  logic        frame_tick;
  logic        up, down, left, right, fire_pulse, paused, any_key;

  int passes = 0;
  int fails  = 0;
  int total  = 0;

  logic [6:0] outs;
  logic [6:0] mid;
  assign outs = {up, down, left, right, paused, any_key, fire_pulse};

  localparam logic [6:0] O_NONE = 7'b0000000;
  localparam logic [6:0] O_UP   = 7'b1000000;
  localparam logic [6:0] O_RT   = 7'b0001000;
  localparam logic [6:0] O_PS   = 7'b0000100;
  localparam logic [6:0] O_ANY  = 7'b0000010;
  localparam logic [6:0] O_FIRE = 7'b0000001;

  keycode_decoder #(.REPEAT_DELAY(20), .REPEAT_PERIOD(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .keycode    (keycode),
    .frame_tick (frame_tick),
    .up         (up),
    .down       (down),
    .left       (left),
    .right      (right),
    .fire_pulse (fire_pulse),
    .paused     (paused),
    .any_key    (any_key)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One frame: tick sampled at the next posedge; returns just after the
  // tick_d edge, with the mid-frame (pre-update) outputs captured in mid.
  task automatic tick(input logic [23:0] kc);
    @(negedge clk);
    keycode    = kc;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    mid = outs;
    @(negedge clk);
  endtask

  initial begin
    reset      = 1'b1;
    frame_tick = 1'b0;
    keycode    = 24'h0;
    repeat (2) @(negedge clk);
    check("reset_outs", outs, O_NONE);
    reset = 1'b0;

    // First snapshot: W alone
    tick(24'h00001A);
    check("lat_before_tick_d", mid, O_NONE);
    check("w_up", outs, O_UP | O_ANY);

    // Keycode changes without a tick are ignored
    keycode = 24'h000016;
    repeat (4) @(negedge clk);
    check("no_tick_hold", outs, O_UP | O_ANY);

    // Up/down cancel, right survives
    tick(24'h1A1607);
    check("ud_cancel", outs, O_RT | O_ANY);

    // Left/right cancel
    tick(24'h000704);
    check("lr_cancel", outs, O_ANY);

    // Empty snapshot
    tick(24'h000000);
    check("empty", outs, O_NONE);

    // Back-to-back ticks
    @(negedge clk);
    keycode    = 24'h00001A;
    frame_tick = 1'b1;
    @(negedge clk);
    keycode    = 24'h000007;
    @(negedge clk);
    frame_tick = 1'b0;
    check("b2b_first", outs, O_UP | O_ANY);
    @(negedge clk);
    check("b2b_second", outs, O_RT | O_ANY);
    tick(24'h000000);
    check("b2b_clear", outs, O_NONE);

    // Space held 40 frames: pulses at 0, 20, 26, 32, 38, each one clk wide
    for (int i = 0; i < 40; i++) begin
      tick(24'h00002C);
      if (i == 0 || i == 20 || i == 26 || i == 32 || i == 38) begin
        check($sformatf("fire_hold_%0d", i), outs, O_ANY | O_FIRE);
        @(negedge clk);
        check($sformatf("fire_width_%0d", i), outs, O_ANY);
      end else begin
        check($sformatf("fire_hold_%0d", i), outs, O_ANY);
      end
    end
    for (int i = 0; i < 8; i++) begin
      tick(24'h000000);
      check($sformatf("fire_release_%0d", i), outs, O_NONE);
    end

    // Esc toggles pause on press edges only
    tick(24'h000029);
    check("esc_press1", outs, O_PS | O_ANY);
    tick(24'h000029);
    check("esc_hold2", outs, O_PS | O_ANY);
    tick(24'h000029);
    check("esc_hold3", outs, O_PS | O_ANY);
    tick(24'h00001A);
    check("paused_dir_forced", outs, O_PS | O_ANY);
    tick(24'h000029);
    check("esc_press2_unpause", outs, O_ANY);
    tick(24'h00001A);
    check("unpaused_up", outs, O_UP | O_ANY);

    // Pause and fire in the same snapshot: pause wins
    tick(24'h002C29);
    check("pause_fire_same", outs, O_PS | O_ANY);
    tick(24'h00002C);
    check("paused_fire_held", outs, O_PS | O_ANY);
    tick(24'h002C29);
    check("unpause_fire_held", outs, O_ANY);
    tick(24'h00002C);
    check("fire_still_held", outs, O_ANY);
    tick(24'h000000);
    check("fire_released", outs, O_NONE);
    tick(24'h00002C);
    check("fire_fresh_press", outs, O_ANY | O_FIRE);

    // Rollover snapshot discarded
    tick(24'h00001A);
    check("pre_rollover_up", outs, O_UP | O_ANY);
    tick(24'h01012C);
    check("rollover_hold", outs, O_UP | O_ANY);
    tick(24'h00002C);
    check("post_rollover_fire", outs, O_ANY | O_FIRE);

    // Hold into REPEAT, then reset mid-repeat
    for (int k = 1; k <= 20; k++) begin
      tick(24'h00002C);
      check($sformatf("rep_hold_%0d", k), outs, (k == 20) ? (O_ANY | O_FIRE) : O_ANY);
    end
    reset = 1'b1;
    #1;
    check("async_reset_outs", outs, O_NONE);
    @(negedge clk);
    reset = 1'b0;
    tick(24'h00002C);
    check("post_reset_press", outs, O_ANY | O_FIRE);
    @(negedge clk);
    check("post_reset_width", outs, O_ANY);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
